fdiv: RTL

FDIV -- requirements
Module: fdiv

---
 rtl/fdiv.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/fdiv.sv
// fdiv: multi-cycle IEEE-754 binary32 divider, round-to-nearest-even.
// One request is accepted while idle. The result appears 27 edges later,
// whatever the operand class.
module fdiv #(
    parameter logic [31:0] DEFAULT_NAN = 32'hFFC00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        busy,
    output logic        valid,
    output logic [31:0] rslt,
    output logic [4:0]  flag
);

    typedef enum logic [1:0] {IDLE, PRE, ITER, RND} state_t;

    state_t             state;
    state_t             state_next;
    logic [4:0]         cnt;
    logic [31:0]        xr;
    logic [31:0]        yr;
    logic signed [9:0]  expr;
    logic [23:0]        my_r;
    logic [25:0]        rem;
    logic [24:0]        q;

    // Count the leading zeros of a 24-bit significand (returns 24 for zero).
    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + 5'd1;
            end
        end
        return n;
    endfunction

    // Unpack an operand into {exponent[9:0], significand[23:0]}, with bit 23 set.
    // Subnormals are normalised and their exponent is lowered to match.
    function automatic logic [33:0] normalize(input logic [31:0] a);
        logic [4:0] lz;
        if (a[30:23] == 8'd0) begin
            lz = lzc24({1'b0, a[22:0]});
            return {10'd1 - {5'd0, lz}, ({1'b0, a[22:0]} << lz)};
        end
        return {2'b00, a[30:23], 1'b1, a[22:0]};
    endfunction

    // Operand classification and special-case results, taken from the held operands.
    logic        x_nan, y_nan, x_snan, y_snan, x_inf, y_inf, x_zero, y_zero;
    logic        sign;
    logic        sp_hit;
    logic [31:0] sp_res;
    logic [4:0]  sp_flag;

    assign x_nan  = (xr[30:23] == 8'hFF) && (xr[22:0] != 23'd0);
    assign y_nan  = (yr[30:23] == 8'hFF) && (yr[22:0] != 23'd0);
    assign x_snan = x_nan && !xr[22];
    assign y_snan = y_nan && !yr[22];
    assign x_inf  = (xr[30:23] == 8'hFF) && (xr[22:0] == 23'd0);
    assign y_inf  = (yr[30:23] == 8'hFF) && (yr[22:0] == 23'd0);
    assign x_zero = (xr[30:0] == 31'd0);
    assign y_zero = (yr[30:0] == 31'd0);
    assign sign   = xr[31] ^ yr[31];

    // Select the special-case result; sp_hit is cleared for ordinary finite division.
    always_comb begin
        sp_hit  = 1'b1;
        sp_res  = 32'd0;
        sp_flag = 5'd0;
        if (x_nan) begin
            sp_res  = xr | 32'h00400000;
            sp_flag = {x_snan | y_snan, 4'b0000};
        end else if (y_nan) begin
            sp_res  = yr | 32'h00400000;
            sp_flag = {y_snan, 4'b0000};
        end else if ((x_inf && y_inf) || (x_zero && y_zero)) begin
            sp_res  = DEFAULT_NAN;
            sp_flag = 5'b10000;
        end else if (x_inf) begin
            sp_res  = {sign, 8'hFF, 23'd0};
        end else if (y_zero) begin
            sp_res  = {sign, 8'hFF, 23'd0};
            sp_flag = 5'b01000;
        end else if (y_inf || x_zero) begin
            sp_res  = {sign, 31'd0};
        end else begin
            sp_hit  = 1'b0;
        end
    end

    // Pre-processing: normalise both significands, form the biased exponent and
    // align the dividend so that the quotient falls in [1,2).
    logic [33:0]        nx, ny;
    logic signed [9:0]  pre_expr;
    logic [25:0]        pre_rem;

    assign nx = normalize(xr);
    assign ny = normalize(yr);

    // Form the starting exponent and remainder for the restoring iteration.
    always_comb begin
        pre_expr = $signed(nx[33:24]) - $signed(ny[33:24]) + 10'sd127;
        pre_rem  = {2'b00, nx[23:0]};
        if (nx[23:0] < ny[23:0]) begin
            pre_rem  = {1'b0, nx[23:0], 1'b0};
            pre_expr = pre_expr - 10'sd1;
        end
    end

    // Rounding: denormalise tiny quotients, then round to nearest even. The
    // hidden bit is added into the exponent field, so a rounding carry moves
    // naturally into the exponent, including subnormal to normal.
    logic               tiny;
    logic signed [9:0]  sh_full;
    logic [4:0]         sh;
    logic [50:0]        wide;
    logic [24:0]        qs;
    logic               sticky;
    logic               guard;
    logic               rup;
    logic               nx_flag;
    logic [7:0]         exp_base;
    logic [30:0]        packed_res;
    logic               ovf;
    logic [31:0]        rnd_res;
    logic [4:0]         rnd_flag;

    // Assemble the rounded result and its exception flags.
    always_comb begin
        tiny     = (expr < 10'sd1);
        sh_full  = 10'sd1 - expr;
        sh       = 5'd0;
        if (tiny) sh = (sh_full > 10'sd26) ? 5'd26 : sh_full[4:0];
        wide     = {q, 26'd0} >> sh;
        qs       = wide[50:26];
        sticky   = (rem != 26'd0) || (wide[25:0] != 26'd0);
        guard    = qs[0];
        rup      = guard && (sticky || qs[1]);
        nx_flag  = guard || sticky;
        exp_base = tiny ? 8'd0 : (expr[7:0] - 8'd1);
        packed_res = {exp_base, 23'd0} + {7'd0, qs[24:1]} + {30'd0, rup};
        ovf      = (!tiny && (expr > 10'sd254)) || (packed_res[30:23] == 8'hFF);
        rnd_res  = {sign, packed_res};
        rnd_flag = {2'b00, 1'b0, tiny && nx_flag, nx_flag};
        if (ovf) begin
            rnd_res  = {sign, 8'hFF, 23'd0};
            rnd_flag = 5'b00101;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic: fixed-length sequence PRE, 25 x ITER, RND.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req) state_next = PRE;
            PRE:  state_next = ITER;
            ITER: if (cnt == 5'd24) state_next = RND;
            RND:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Datapath: operand capture, restoring iteration and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xr    <= 32'd0;
            yr    <= 32'd0;
            expr  <= 10'sd0;
            my_r  <= 24'd0;
            rem   <= 26'd0;
            q     <= 25'd0;
            cnt   <= 5'd0;
            valid <= 1'b0;
            rslt  <= 32'd0;
            flag  <= 5'd0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        xr <= x;
                        yr <= y;
                    end
                end
                PRE: begin
                    expr <= pre_expr;
                    rem  <= pre_rem;
                    my_r <= ny[23:0];
                    q    <= 25'd0;
                    cnt  <= 5'd0;
                end
                ITER: begin
                    cnt <= cnt + 5'd1;
                    if (rem >= {2'b00, my_r}) begin
                        q   <= {q[23:0], 1'b1};
                        rem <= (rem - {2'b00, my_r}) << 1;
                    end else begin
                        q   <= {q[23:0], 1'b0};
                        rem <= rem << 1;
                    end
                end
                RND: begin
                    valid <= 1'b1;
                    rslt  <= sp_hit ? sp_res  : rnd_res;
                    flag  <= sp_hit ? sp_flag : rnd_flag;
                end
                default: ;
            endcase
        end
    end

endmodule
